// File: rtl/osc_pkg.sv
// osc_pkg: widths and sample type shared by the sinusoidal-oscillator chain.
package osc_pkg;
    localparam int SAMPLE_W = 14;
    localparam int FILT_W   = 20;
    localparam int PAD_W    = 6;
    typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/strobe_edge_detect.sv
// strobe_edge_detect: synchronizes an asynchronous strobe and flags its rising edges.
module strobe_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic strobe,
    output logic tick
);
    logic s1, s2, s3;

    // Preset to 1 so a strobe already high at reset release is not taken as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) {s1, s2, s3} <= 3'b111;
        else     {s1, s2, s3} <= {strobe, s1, s2};
    end

    assign tick = s2 & ~s3;
endmodule

// File: rtl/square_wave_source.sv
// square_wave_source: +/-amplitude square wave (or raw ADC bypass) produced once per
// sample strobe, left-aligned into the 20-bit low-pass cascade input.
module square_wave_source
    import osc_pkg::*;
#(
    parameter int HP_W = 16
) (
    input  logic              qzt_clk,
    input  logic              reset,
    input  logic              sample_clk,
    input  logic              enable,
    input  logic              src_sel,
    input  logic [HP_W-1:0]   half_period,
    input  logic [12:0]       amplitude,
    input  logic [13:0]       adc_sample,
    output logic [FILT_W-1:0] Vout,
    output logic              sample_valid,
    output logic              sync,
    output logic              phase
);
    logic            tick, primed, wrap, rise, phase_n;
    logic [HP_W-1:0] count, count_n, hp_l, hp_in;
    logic [12:0]     amp_l, amp_n;
    sample_t         mag, sample;

    strobe_edge_detect u_edge (
        .clk    (qzt_clk),
        .rst    (reset),
        .strobe (sample_clk),
        .tick   (tick)
    );

    // Parameters are re-latched only at a rising transition so each period is whole.
    always_comb begin
        hp_in   = (half_period == '0) ? HP_W'(1) : half_period;
        wrap    = primed && (count == hp_l - HP_W'(1));
        rise    = !primed || (wrap && !phase);
        phase_n = !primed || (wrap ? !phase : phase);
        count_n = (!primed || wrap) ? '0 : count + HP_W'(1);
        amp_n   = rise ? amplitude : amp_l;
        mag     = sample_t'({1'b0, amp_n});
        sample  = src_sel ? sample_t'(adc_sample) : (phase_n ? mag : -mag);
    end

    always_ff @(posedge qzt_clk or posedge reset) begin
        if (reset) begin
            Vout         <= '0;
            sample_valid <= 1'b0;
            sync         <= 1'b0;
            phase        <= 1'b0;
            count        <= '0;
            primed       <= 1'b0;
            hp_l         <= HP_W'(1);
            amp_l        <= '0;
        end else if (!enable) begin
            Vout         <= '0;
            sample_valid <= 1'b0;
            sync         <= 1'b0;
            phase        <= 1'b0;
            count        <= '0;
            primed       <= 1'b0;
            hp_l         <= HP_W'(1);
            amp_l        <= '0;
        end else begin
            sample_valid <= tick;
            sync         <= tick && rise;
            if (tick) begin
                count  <= count_n;
                phase  <= phase_n;
                primed <= 1'b1;
                Vout   <= {sample, {PAD_W{1'b0}}};
                if (rise) begin
                    hp_l  <= hp_in;
                    amp_l <= amplitude;
                end
            end
        end
    end
endmodule

// File: tb/tb_square_wave_source.sv
// tb_square_wave_source: scoreboard bench; a period-position model predicts each sample.
module tb_square_wave_source;
    logic        qzt_clk = 0, reset = 1, sample_clk = 0, enable = 0, src_sel = 0;
    logic [15:0] half_period = 16'd3;
    logic [12:0] amplitude = 13'd1000;
    logic [13:0] adc_sample = '0;
    logic [19:0] Vout;
    logic        sample_valid, sync, phase;

    int n_checks = 0, n_pass = 0;
    logic [21:0] exp_q[$];

    bit m_primed = 0;
    int m_p = 0, m_hp = 1, m_amp = 0;

    square_wave_source #(.HP_W(16)) dut (
        .qzt_clk(qzt_clk), .reset(reset), .sample_clk(sample_clk), .enable(enable),
        .src_sel(src_sel), .half_period(half_period), .amplitude(amplitude),
        .adc_sample(adc_sample), .Vout(Vout), .sample_valid(sample_valid),
        .sync(sync), .phase(phase)
    );

    always #5 qzt_clk = ~qzt_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endtask

    // Position p within the current 2*hp-tick period; positive half while p < hp.
    task automatic model_tick();
        int hp, s;
        bit sy, ph;
        logic [19:0] v;
        if (!enable) begin
            m_primed = 0;
            return;
        end
        hp = (half_period == 0) ? 1 : int'(half_period);
        sy = 0;
        if (!m_primed) begin
            m_primed = 1; m_p = 0; m_hp = hp; m_amp = int'(amplitude); sy = 1;
        end else begin
            m_p++;
            if (m_p == 2 * m_hp) begin
                m_p = 0; m_hp = hp; m_amp = int'(amplitude); sy = 1;
            end
        end
        ph = (m_p < m_hp);
        s = src_sel ? int'($signed(adc_sample)) : (ph ? m_amp : -m_amp);
        v = 20'(s * 64);
        exp_q.push_back({v, sy, ph});
    endtask

    task automatic do_tick(input int hi, input int lo);
        model_tick();
        @(negedge qzt_clk) sample_clk = 1;
        repeat (hi) @(negedge qzt_clk);
        sample_clk = 0;
        repeat (lo) @(negedge qzt_clk);
    endtask

    task automatic rnd_tick();
        do_tick($urandom_range(2, 4), $urandom_range(2, 5));
    endtask

    always @(negedge qzt_clk) begin
        if (!reset) begin
            if (sample_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_pulse: Vout %0h with nothing expected at %0t", Vout, $time);
                end else begin
                    logic [21:0] e;
                    e = exp_q.pop_front();
                    chk("vout", 32'(Vout), 32'(e[21:2]));
                    chk("sync", 32'(sync), 32'(e[1]));
                    chk("phase", 32'(phase), 32'(e[0]));
                end
            end else if (sync) begin
                n_checks++;
                $display("FAIL sync_without_valid: sync 1 required 0 at %0t", $time);
            end
        end
    end

    initial begin
        repeat (3) @(negedge qzt_clk);
        chk("rst_vout", 32'(Vout), 0);
        chk("rst_valid", 32'(sample_valid), 0);
        chk("rst_phase", 32'(phase), 0);
        reset = 0; enable = 1;
        repeat (3) @(negedge qzt_clk);
        chk("no_tick_after_rst", 32'(sample_valid), 0);

        // basic 3-tick half period
        half_period = 3; amplitude = 1000;
        repeat (12) rnd_tick();
        // half_period 0 acts as 1, full-scale amplitude
        half_period = 0; amplitude = 8191;
        repeat (4) rnd_tick();
        // amplitude change mid-half takes effect only at the next rising transition
        half_period = 3; amplitude = 1000;
        repeat (7) rnd_tick();
        amplitude = 2000;
        repeat (8) rnd_tick();
        // ADC bypass, generator keeps running
        src_sel = 1; adc_sample = 14'h3FFF;
        repeat (4) rnd_tick();
        src_sel = 0;
        repeat (4) rnd_tick();

        // disable mid-period: cleared, ticks ignored
        enable = 0;
        repeat (2) rnd_tick();
        chk("dis_vout", 32'(Vout), 0);
        chk("dis_phase", 32'(phase), 0);
        enable = 1; amplitude = 500;
        repeat (3) rnd_tick();

        // enable drop coincident with the tick edge
        @(negedge qzt_clk) sample_clk = 1;
        @(negedge qzt_clk);
        @(negedge qzt_clk) enable = 0;
        m_primed = 0;
        @(negedge qzt_clk) sample_clk = 0;
        chk("coinc_valid", 32'(sample_valid), 0);
        chk("coinc_vout", 32'(Vout), 0);
        repeat (3) @(negedge qzt_clk);
        enable = 1;
        repeat (2) rnd_tick();

        // asynchronous reset mid-period
        @(negedge qzt_clk);
        #2 reset = 1;
        #1;
        chk("arst_vout", 32'(Vout), 0);
        chk("arst_phase", 32'(phase), 0);
        m_primed = 0;

        // strobe held high through reset release, then exact k+2 latency
        sample_clk = 1;
        @(negedge qzt_clk) reset = 0;
        repeat (4) @(negedge qzt_clk);
        chk("held_high_no_tick", 32'(sample_valid), 0);
        sample_clk = 0;
        repeat (3) @(negedge qzt_clk);
        half_period = 2; amplitude = 123;
        model_tick();
        sample_clk = 1;
        @(posedge qzt_clk) #1 chk("lat_k", 32'(sample_valid), 0);
        @(posedge qzt_clk) #1 chk("lat_k1", 32'(sample_valid), 0);
        @(posedge qzt_clk) #1 chk("lat_k2", 32'(sample_valid), 1);
        @(negedge qzt_clk);
        sample_clk = 0;
        repeat (3) @(negedge qzt_clk);

        // randomized run
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) half_period = 16'($urandom_range(0, 5));
            if ($urandom_range(0, 5) == 0) amplitude = 13'($urandom);
            if ($urandom_range(0, 9) == 0) src_sel = ~src_sel;
            adc_sample = 14'($urandom);
            enable = ($urandom_range(0, 19) != 0);
            rnd_tick();
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge qzt_clk);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
